// File: rtl/nibble_parity_frame_checker_pkg.sv
// Shared types and constants for the nibble parity frame checker.
package nibble_parity_frame_checker_pkg;
  localparam int NIB_W    = 4;
  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    REPORT = 2'd2
  } state_t;
endpackage

// File: rtl/nibble_parity_frame_checker_if.sv
// Nibble stream in, frame result and statistics out.
// The slave modport is the checker; the master modport is the upstream/observer.
interface nibble_parity_frame_checker_if #(parameter int CNT_W = 8);
  import nibble_parity_frame_checker_pkg::*;

  logic             i_valid;
  logic             o_ready;
  logic [NIB_W-1:0] i_nibble;
  logic             i_last;
  logic             i_par_exp;
  logic             o_done;
  logic             o_par;
  logic             o_err;
  logic             o_ovf;
  logic [CNT_W-1:0] o_count;
  logic [CNT_W-1:0] o_frame_cnt;
  logic [CNT_W-1:0] o_err_cnt;

  modport master (
    output i_valid, i_nibble, i_last, i_par_exp,
    input  o_ready, o_done, o_par, o_err, o_ovf, o_count, o_frame_cnt, o_err_cnt
  );

  modport slave (
    input  i_valid, i_nibble, i_last, i_par_exp,
    output o_ready, o_done, o_par, o_err, o_ovf, o_count, o_frame_cnt, o_err_cnt
  );
endinterface

// File: rtl/nibble_parity_frame_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module nibble_parity_frame_checker_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  // Count up on i_inc unless already saturated; clear has priority.
  always_ff @(posedge i_clk) begin
    if (i_clr)                     r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/nibble_parity_frame_checker.sv
// Frame parity checker: folds per-nibble XOR parity over a frame, compares
// against the expected bit carried on the last beat and reports one result
// per frame, plus saturating frame/error statistics.
module nibble_parity_frame_checker #(
  parameter int CNT_W   = 8,
  parameter int MAX_NIB = 200,
  parameter bit PAR_ODD = 1'b0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  nibble_parity_frame_checker_if.slave  bus
);
  import nibble_parity_frame_checker_pkg::*;

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_NIB);

  state_t           r_state, w_state_nxt;
  logic             w_ready, w_report;
  logic             r_acc, r_ovf;
  logic [CNT_W-1:0] r_len;
  logic             r_par_o, r_err_o, r_ovf_o;
  logic [CNT_W-1:0] r_count_o;

  logic             w_accept, w_rpt, w_nib_par;
  logic             w_acc_nxt, w_ovf_nxt, w_par_calc, w_err_calc;
  logic [CNT_W-1:0] w_len_nxt;
  logic [CNT_W-1:0] w_frame_cnt, w_err_cnt;

  assign w_nib_par = ^bus.i_nibble;
  assign w_accept  = bus.i_valid & w_ready;
  assign w_rpt     = w_accept & bus.i_last;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus handshake/report strobes. Ready is only dropped in REPORT,
  // so in IDLE/ACC an accepted beat is simply i_valid.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b1;
    w_report    = 1'b0;
    case (r_state)
      IDLE:    if (bus.i_valid) w_state_nxt = bus.i_last ? REPORT : ACC;
      ACC:     if (bus.i_valid && bus.i_last) w_state_nxt = REPORT;
      REPORT:  begin
        w_ready     = 1'b0;
        w_report    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Accumulator/length update for the beat being accepted; beats past MAX_NIB
  // only flag overflow and are not folded into the parity.
  always_comb begin
    w_acc_nxt = r_acc;
    w_len_nxt = r_len;
    w_ovf_nxt = r_ovf;
    if (r_state == IDLE) begin
      w_acc_nxt = w_nib_par;
      w_len_nxt = CNT_W'(1);
      w_ovf_nxt = 1'b0;
    end else if (r_len < LP_MAX) begin
      w_acc_nxt = r_acc ^ w_nib_par;
      w_len_nxt = r_len + 1'b1;
    end else begin
      w_ovf_nxt = 1'b1;
    end
  end

  // Result is resolved on the last beat so it is already on the outputs when
  // o_done pulses in REPORT; i_par_exp never needs storing beyond that edge.
  assign w_par_calc = w_acc_nxt ^ PAR_ODD;
  assign w_err_calc = (w_par_calc != bus.i_par_exp) | w_ovf_nxt;

  // Frame accumulator and held result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc     <= 1'b0;
      r_len     <= '0;
      r_ovf     <= 1'b0;
      r_par_o   <= 1'b0;
      r_err_o   <= 1'b0;
      r_ovf_o   <= 1'b0;
      r_count_o <= '0;
    end else if (r_state == REPORT) begin
      r_acc <= 1'b0;
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_nxt;
      r_len <= w_len_nxt;
      r_ovf <= w_ovf_nxt;
      if (bus.i_last) begin
        r_par_o   <= w_par_calc;
        r_err_o   <= w_err_calc;
        r_ovf_o   <= w_ovf_nxt;
        r_count_o <= w_len_nxt;
      end
    end
  end

  nibble_parity_frame_checker_sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .i_clk (i_clk),
    .i_clr (i_rst),
    .i_inc (w_rpt),
    .o_cnt (w_frame_cnt)
  );

  nibble_parity_frame_checker_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .i_clk (i_clk),
    .i_clr (i_rst),
    .i_inc (w_rpt & w_err_calc),
    .o_cnt (w_err_cnt)
  );

  assign bus.o_ready     = w_ready;
  // Reset asserted during REPORT suppresses that cycle's pulse.
  assign bus.o_done      = w_report & ~i_rst;
  assign bus.o_par       = r_par_o;
  assign bus.o_err       = r_err_o;
  assign bus.o_ovf       = r_ovf_o;
  assign bus.o_count     = r_count_o;
  assign bus.o_frame_cnt = w_frame_cnt;
  assign bus.o_err_cnt   = w_err_cnt;
endmodule
